icache_refill_ctrl: RTL and testbench

Refill controller sitting directly upstream of the instruction cache set array. On an instruction-cache miss it issues a block read to the memory interface, collects the returned 64-bit beats, and streams them to the cache set as `RepWord`/`RepReady`. It holds the fetch stage stalled until the refilled block produces a hit.

---
 rtl/icache_refill_ctrl.sv | 127 ++++++++++++
 tb/tb_icache_refill_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller: fetches one block over a 64-bit memory port and streams it to the set array.
// Optional miss/refill-cycle performance counters are enabled by defining ICACHE_REFILL_PERF_EN.
module icache_refill_ctrl #(
    parameter int B      = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] PCF,
    input  logic              CacheMiss,
    output logic              Stall,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic              MemAck,
    input  logic              MemValid,
    input  logic [63:0]       MemData,
    output logic              RepReady,
    output logic [63:0]       RepWord
`ifdef ICACHE_REFILL_PERF_EN
    ,
    output logic [31:0]       MissCount,
    output logic [31:0]       RefillCycles
`endif
);

    localparam int BEATS = B / 8;
    localparam int OFF_W = $clog2(B);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // state | meaning
    // IDLE  | no refill; a miss latches the block address
    // REQ   | MemReq held until MemAck
    // FILL  | forwarding returned beats to the set array
    // WAIT  | last beat draining; waiting for the miss to clear
    typedef enum logic [1:0] {IDLE, REQ, FILL, WAIT} stateT;

    stateT            state;
    stateT            stateNext;
    logic [CNT_W-1:0] beatCnt;
    logic             loadAddr;
    logic             takeBeat;

    // Offset bits of the fetch address are deliberately dropped by block alignment.
    logic unusedPcfOffset;
    assign unusedPcfOffset = ^PCF[OFF_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        MemReq    = 1'b0;
        loadAddr  = 1'b0;
        takeBeat  = 1'b0;
        case (state)
            IDLE: begin
                if (CacheMiss) begin
                    loadAddr  = 1'b1;
                    stateNext = REQ;
                end
            end
            REQ: begin
                MemReq = 1'b1;
                if (MemAck) begin
                    stateNext = FILL;
                end
            end
            FILL: begin
                if (MemValid) begin
                    takeBeat = 1'b1;
                    if (beatCnt == LAST_BEAT) begin
                        stateNext = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!CacheMiss) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        Stall = (state != IDLE) || CacheMiss;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            MemAddr  <= '0;
            beatCnt  <= '0;
            RepReady <= 1'b0;
            RepWord  <= '0;
        end else begin
            RepReady <= takeBeat;
            if (loadAddr) begin
                MemAddr <= {PCF[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                beatCnt <= '0;
            end
            if (takeBeat) begin
                RepWord <= MemData;
                beatCnt <= (beatCnt == LAST_BEAT) ? '0 : beatCnt + 1'b1;
            end
        end
    end

`ifdef ICACHE_REFILL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            MissCount    <= '0;
            RefillCycles <= '0;
        end else begin
            if (loadAddr && (MissCount != 32'hFFFF_FFFF)) begin
                MissCount <= MissCount + 32'd1;
            end
            if ((state != IDLE) && (RefillCycles != 32'hFFFF_FFFF)) begin
                RefillCycles <= RefillCycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: vector table, hand-written corner cases and randomized refills.
// Build with ICACHE_REFILL_PERF_EN defined to also exercise the performance counters.
module tb_icache_refill_ctrl;

    localparam int B      = 64;
    localparam int ADDR_W = 32;
    localparam int BEATS  = B / 8;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] PCF;
    logic              CacheMiss;
    logic              Stall;
    logic              MemReq;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemAck;
    logic              MemValid;
    logic [63:0]       MemData;
    logic              RepReady;
    logic [63:0]       RepWord;
`ifdef ICACHE_REFILL_PERF_EN
    logic [31:0]       MissCount;
    logic [31:0]       RefillCycles;
`endif

    icache_refill_ctrl #(.B(B), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .PCF         (PCF),
        .CacheMiss   (CacheMiss),
        .Stall       (Stall),
        .MemReq      (MemReq),
        .MemAddr     (MemAddr),
        .MemAck      (MemAck),
        .MemValid    (MemValid),
        .MemData     (MemData),
        .RepReady    (RepReady),
        .RepWord     (RepWord)
`ifdef ICACHE_REFILL_PERF_EN
        ,
        .MissCount   (MissCount),
        .RefillCycles(RefillCycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        miss;
        logic        ack;
        logic        valid;
        logic [63:0] data;
        logic        eReq;
        logic        eRdy;
        logic        eStall;
        logic [63:0] eWord;
    } vecT;

    vecT         vecs[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          reqCnt      = 0;
    int          rdyCnt      = 0;
    int          gapTbl[BEATS];
    logic [63:0] modelWord   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expectOut(input logic eReq, input logic eRdy, input logic eStall, input logic [63:0] eWord);
        check("req/rdy/stall", {61'd0, MemReq, RepReady, Stall}, {61'd0, eReq, eRdy, eStall});
        check("repWord", RepWord, eWord);
        if (MemReq) reqCnt++;
        if (RepReady) rdyCnt++;
    endtask

    task automatic addVec(input logic miss, input logic ack, input logic valid, input logic [63:0] data,
                          input logic eReq, input logic eRdy, input logic eStall, input logic [63:0] eWord);
        vecT v;
        v.miss = miss; v.ack = ack; v.valid = valid; v.data = data;
        v.eReq = eReq; v.eRdy = eRdy; v.eStall = eStall; v.eWord = eWord;
        vecs.push_back(v);
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Memory-side driver plus transaction-level expectations for one complete refill.
    task automatic runRefill(input logic [ADDR_W-1:0] pcf, input int ackDelay, input int hold, input bit junk);
        logic [ADDR_W-1:0] blockAddr;
        blockAddr = ADDR_W'((pcf / B) * B);
        reqCnt = 0;
        rdyCnt = 0;
        PCF = pcf; CacheMiss = 1'b1; MemAck = 1'b0;
        MemValid = junk && ($urandom_range(0, 1) == 1); MemData = rand64();
        step();
        expectOut(1'b1, 1'b0, 1'b1, modelWord);
        check("memAddr", {32'd0, MemAddr}, {32'd0, blockAddr});
        for (int j = 0; j <= ackDelay; j++) begin
            MemAck = (j == ackDelay);
            MemValid = junk && ($urandom_range(0, 1) == 1); MemData = rand64();
            step();
            expectOut(j < ackDelay, 1'b0, 1'b1, modelWord);
        end
        MemAck = 1'b0;
        for (int i = 0; i < BEATS; i++) begin
            for (int g = 0; g < gapTbl[i]; g++) begin
                MemValid = 1'b0; MemData = rand64();
                step();
                expectOut(1'b0, 1'b0, 1'b1, modelWord);
            end
            MemValid = 1'b1; MemData = rand64(); modelWord = MemData;
            step();
            expectOut(1'b0, 1'b1, 1'b1, modelWord);
        end
        for (int h = 0; h < hold; h++) begin
            MemValid = junk && ($urandom_range(0, 1) == 1); MemData = rand64();
            step();
            expectOut(1'b0, 1'b0, 1'b1, modelWord);
        end
        CacheMiss = 1'b0;
        MemValid = junk && ($urandom_range(0, 1) == 1); MemData = rand64();
        step();
        expectOut(1'b0, 1'b0, 1'b0, modelWord);
        check("reqCycles", 64'(reqCnt), 64'(ackDelay + 1));
        check("rdyPulses", 64'(rdyCnt), 64'(BEATS));
        check("memAddrHeld", {32'd0, MemAddr}, {32'd0, blockAddr});
        MemValid = 1'b0;
    endtask

    initial begin
        int idleN;
        reset = 1'b0; CacheMiss = 1'b1; PCF = 32'h0000_1234;
        MemAck = 1'b0; MemValid = 1'b0; MemData = '0;
        foreach (gapTbl[i]) gapTbl[i] = 0;

        // Reset held with a pending miss: nothing may leave the block.
        #1;
        expectOut(1'b0, 1'b0, 1'b1, 64'd0);
        check("memAddrRst", {32'd0, MemAddr}, 64'd0);
        repeat (2) begin
            step();
            expectOut(1'b0, 1'b0, 1'b1, 64'd0);
        end
        reset = 1'b1;

        // Back-to-back refill, then a 5-cycle WAIT hold and the drop back to IDLE.
        addVec(1, 0, 0, 64'h0,  1, 0, 1, 64'h0);
        addVec(1, 1, 0, 64'h0,  0, 0, 1, 64'h0);
        for (int i = 0; i < 8; i++) addVec(1, 0, 1, 64'hA0 + 64'(i), 0, 1, 1, 64'hA0 + 64'(i));
        for (int k = 0; k < 5; k++) addVec(1, 0, (k == 2), 64'hDEAD, 0, 0, 1, 64'hA7);
        addVec(0, 0, 0, 64'h0,    0, 0, 0, 64'hA7);
        addVec(0, 0, 1, 64'hBEEF, 0, 0, 0, 64'hA7);
        foreach (vecs[i]) begin
            CacheMiss = vecs[i].miss; MemAck = vecs[i].ack;
            MemValid = vecs[i].valid; MemData = vecs[i].data;
            step();
            expectOut(vecs[i].eReq, vecs[i].eRdy, vecs[i].eStall, vecs[i].eWord);
        end
        check("memAddrB2B", {32'd0, MemAddr}, 64'h0000_1200);
        modelWord = 64'hA7;
        MemValid = 1'b0;

        // Slow memory: ack after 3 cycles, 2-cycle gap after the fourth beat.
        gapTbl[4] = 2;
        runRefill(32'h0000_5678, 3, 1, 1'b0);
        gapTbl[4] = 0;

        // Reset in the middle of FILL, then a clean refill from a fresh counter.
        PCF = 32'h0000_3456; CacheMiss = 1'b1; step();
        MemAck = 1'b1; step();
        MemAck = 1'b0;
        for (int i = 0; i < 4; i++) begin
            MemValid = 1'b1; MemData = 64'hC0 + 64'(i); step();
        end
        MemValid = 1'b1; MemData = 64'hC4;
        #2 reset = 1'b0;
        #1;
        expectOut(1'b0, 1'b0, 1'b1, 64'd0);
        check("memAddrMidRst", {32'd0, MemAddr}, 64'd0);
        step();
        expectOut(1'b0, 1'b0, 1'b1, 64'd0);
        CacheMiss = 1'b0; MemValid = 1'b0; reset = 1'b1;
        step();
        expectOut(1'b0, 1'b0, 1'b0, 64'd0);
        modelWord = '0;
        runRefill(32'h0000_2000, 0, 0, 1'b0);

        // Randomized refills with idle gaps, junk beats, varied ack delay, beat gaps and hold.
        for (int t = 0; t < 25; t++) begin
            idleN = $urandom_range(0, 2);
            for (int k = 0; k < idleN; k++) begin
                CacheMiss = 1'b0; MemAck = 1'($urandom_range(0, 1));
                MemValid = 1'($urandom_range(0, 1)); MemData = rand64();
                step();
                expectOut(1'b0, 1'b0, 1'b0, modelWord);
            end
            MemAck = 1'b0;
            foreach (gapTbl[i]) gapTbl[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            runRefill($urandom, $urandom_range(0, 4), $urandom_range(0, 4), 1'b1);
        end

`ifdef ICACHE_REFILL_PERF_EN
        foreach (gapTbl[i]) gapTbl[i] = 0;
        reset = 1'b0; CacheMiss = 1'b0; MemValid = 1'b0; MemAck = 1'b0;
        step();
        reset = 1'b1; modelWord = '0;
        step();
        check("missCountRst", {32'd0, MissCount}, 64'd0);
        check("refillCyclesRst", {32'd0, RefillCycles}, 64'd0);
        runRefill(32'h0000_0100, 0, 0, 1'b0);
        runRefill(32'h0000_0200, 2, 0, 1'b0);
        gapTbl[4] = 2;
        runRefill(32'h0000_0300, 1, 2, 1'b0);
        step();
        check("missCount", {32'd0, MissCount}, 64'd3);
        check("refillCycles", {32'd0, RefillCycles}, 64'd37);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
